// File: rtl/pb_io_pkg.sv
// Shared PicoBlaze I/O definitions: port-id map, helper math, button FSM state type.
package pb_io_pkg;

    localparam logic [7:0] PB_PORT_UART_RX    = 8'h02;
    localparam logic [7:0] PB_PORT_UART_TX    = 8'h03;
    localparam logic [7:0] PB_PORT_UART_DP    = 8'h04;
    localparam logic [7:0] PB_PORT_UART_FULL  = 8'h05;
    localparam logic [7:0] PB_PORT_BTN_LEVEL  = 8'h06;
    localparam logic [7:0] PB_PORT_BTN_EVENT  = 8'h07;
    localparam logic [7:0] PB_PORT_BTN_MASK   = 8'h0C;
    localparam logic [7:0] PB_PORT_BTN_REPEAT = 8'h0D;

    // Auto-repeat channel state
    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        longint unsigned span;
        result = 0;
        span   = 1;
        while (span < longint'(value)) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop sync, debounce, press detect and auto-repeat.
module btn_debounce
    import pb_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk100MHz,
    input  logic pb_reset,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_stable,
    output logic o_press_pulse_c
);

    localparam int unsigned DB_W    = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = (clog2(REP_MAX) < 1) ? 1 : clog2(REP_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [1:0]       r_sync;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_stable;
    logic             r_stable_q;
    rep_state_e       r_state;
    rep_state_e       w_state_nxt;
    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_nxt;
    logic             w_rise;
    logic             w_rep;

    // Bring the raw pin into the clock domain
    always_ff @(posedge clk100MHz or posedge pb_reset) begin
        if (pb_reset) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], i_btn};
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES
    always_ff @(posedge clk100MHz or posedge pb_reset) begin
        if (pb_reset) begin
            r_db_cnt   <= '0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
        end else begin
            r_stable_q <= r_stable;
            if (r_sync[1] == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_stable <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_q;

    // Repeat FSM state register
    always_ff @(posedge clk100MHz or posedge pb_reset) begin
        if (pb_reset) begin
            r_state   <= REP_IDLE;
            r_rep_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end

    // Repeat FSM next state; release or repeat disable drops straight to idle
    always_comb begin
        w_state_nxt   = r_state;
        w_rep_cnt_nxt = r_rep_cnt;
        case (r_state)
            REP_IDLE: begin
                w_rep_cnt_nxt = '0;
                if (w_rise && i_repeat_en) w_state_nxt = REP_DELAY;
            end
            REP_DELAY, REP_REPEAT: begin
                if (!r_stable || !i_repeat_en) begin
                    w_state_nxt   = REP_IDLE;
                    w_rep_cnt_nxt = '0;
                end else if (w_rep) begin
                    w_state_nxt   = REP_REPEAT;
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
                end
            end
            default: begin
                w_state_nxt   = REP_IDLE;
                w_rep_cnt_nxt = '0;
            end
        endcase
    end

    // Repeat FSM output; gated so no repeat fires in the release cycle
    always_comb begin
        w_rep = 1'b0;
        case (r_state)
            REP_DELAY:  w_rep = r_stable && i_repeat_en && (r_rep_cnt == DELAY_LAST);
            REP_REPEAT: w_rep = r_stable && i_repeat_en && (r_rep_cnt == PERIOD_LAST);
            default:    w_rep = 1'b0;
        endcase
    end

    assign o_stable        = r_stable;
    assign o_press_pulse_c = w_rise | w_rep;

endmodule

// File: rtl/pb_button_port.sv
// PicoBlaze input-port peripheral for front-panel buttons: levels, latched events, mask, repeat.
module pb_button_port
    import pb_io_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter logic [7:0]  PORT_LEVEL      = PB_PORT_BTN_LEVEL,
    parameter logic [7:0]  PORT_EVENT      = PB_PORT_BTN_EVENT,
    parameter logic [7:0]  PORT_MASK       = PB_PORT_BTN_MASK,
    parameter logic [7:0]  PORT_REPEAT     = PB_PORT_BTN_REPEAT
) (
    input  logic               clk100MHz,
    input  logic               pb_reset,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [7:0]         pb_port_id,
    input  logic               pb_read_strobe,
    input  logic               pb_write_strobe,
    input  logic [7:0]         pb_out_port,
    output logic [7:0]         rd_data,
    output logic               rd_hit,
    output logic               event_any
);

    logic [NUM_BTN-1:0] w_stable;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_set;
    logic [NUM_BTN-1:0] w_new_bits;
    logic [NUM_BTN-1:0] w_event_nxt;
    logic [NUM_BTN-1:0] r_event;
    logic [NUM_BTN-1:0] r_mask;
    logic [NUM_BTN-1:0] r_repeat_en;
    logic [7:0]         r_rd_data;
    logic               r_rd_hit;
    logic               r_event_any;
    logic [7:0]         w_rd_mux;
    logic               w_hit;
    logic               w_rd_event;
    logic               w_wr_mask;
    logic               w_wr_repeat;
    logic               w_unused_out;

    // Per-channel conditioning
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_btn (
            .clk100MHz       (clk100MHz),
            .pb_reset        (pb_reset),
            .i_btn           (btn_in[g]),
            .i_repeat_en     (r_repeat_en[g]),
            .o_stable        (w_stable[g]),
            .o_press_pulse_c (w_press[g])
        );
    end

    assign w_new_bits   = pb_out_port[NUM_BTN-1:0];
    assign w_unused_out = ^pb_out_port;
    assign w_set        = w_press & r_mask;
    assign w_rd_event   = pb_read_strobe  && (pb_port_id == PORT_EVENT);
    assign w_wr_mask    = pb_write_strobe && (pb_port_id == PORT_MASK);
    assign w_wr_repeat  = pb_write_strobe && (pb_port_id == PORT_REPEAT);

    // Event update: clear only what was reported, new sets win, mask write drops disabled bits
    always_comb begin
        w_event_nxt = r_event;
        if (w_rd_event) w_event_nxt = w_event_nxt & ~r_rd_data[NUM_BTN-1:0];
        w_event_nxt = w_event_nxt | w_set;
        if (w_wr_mask)  w_event_nxt = w_event_nxt & w_new_bits;
    end

    // Read-data mux for the current port_id
    always_comb begin
        w_rd_mux = 8'h00;
        w_hit    = 1'b0;
        case (pb_port_id)
            PORT_LEVEL:  begin w_rd_mux = 8'(w_stable);    w_hit = 1'b1; end
            PORT_EVENT:  begin w_rd_mux = 8'(r_event);     w_hit = 1'b1; end
            PORT_MASK:   begin w_rd_mux = 8'(r_mask);      w_hit = 1'b1; end
            PORT_REPEAT: begin w_rd_mux = 8'(r_repeat_en); w_hit = 1'b1; end
            default:     begin w_rd_mux = 8'h00;           w_hit = 1'b0; end
        endcase
    end

    // Control/status registers and registered read path
    always_ff @(posedge clk100MHz or posedge pb_reset) begin
        if (pb_reset) begin
            r_event     <= '0;
            r_mask      <= '1;
            r_repeat_en <= '0;
            r_rd_data   <= 8'h00;
            r_rd_hit    <= 1'b0;
            r_event_any <= 1'b0;
        end else begin
            r_event     <= w_event_nxt;
            r_rd_data   <= w_rd_mux;
            r_rd_hit    <= w_hit;
            r_event_any <= |r_event;
            if (w_wr_mask)   r_mask      <= w_new_bits;
            if (w_wr_repeat) r_repeat_en <= w_new_bits;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_hit    = r_rd_hit;
    assign event_any = r_event_any;

endmodule

// File: tb/tb_pb_button_port.sv
// Directed self-checking bench for pb_button_port with short debounce/repeat timing.
module tb_pb_button_port;

    localparam int unsigned NUM_BTN = 5;

    logic               clk100MHz = 1'b0;
    logic               pb_reset;
    logic [NUM_BTN-1:0] btn_in;
    logic [7:0]         pb_port_id;
    logic               pb_read_strobe;
    logic               pb_write_strobe;
    logic [7:0]         pb_out_port;
    logic [7:0]         rd_data;
    logic               rd_hit;
    logic               event_any;

    int n_checks = 0;
    int n_errors = 0;
    int rises[$];
    int exp_rise[6] = '{8, 28, 36, 44, 52, 60};
    logic prev_any;

    pb_button_port #(
        .NUM_BTN         (NUM_BTN),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk100MHz       (clk100MHz),
        .pb_reset        (pb_reset),
        .btn_in          (btn_in),
        .pb_port_id      (pb_port_id),
        .pb_read_strobe  (pb_read_strobe),
        .pb_write_strobe (pb_write_strobe),
        .pb_out_port     (pb_out_port),
        .rd_data         (rd_data),
        .rd_hit          (rd_hit),
        .event_any       (event_any)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk100MHz);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [7:0] id, input logic [7:0] exp, input logic exp_hit);
        pb_port_id = id;
        step(1);
        chk(tag, 32'(rd_data), 32'(exp));
        chk({tag, "_hit"}, 32'(rd_hit), 32'(exp_hit));
    endtask

    task automatic write_port(input logic [7:0] id, input logic [7:0] d);
        pb_port_id      = id;
        pb_out_port     = d;
        pb_write_strobe = 1'b1;
        step(1);
        pb_write_strobe = 1'b0;
        pb_out_port     = 8'h00;
    endtask

    initial begin
        pb_reset        = 1'b1;
        btn_in          = '0;
        pb_port_id      = 8'h00;
        pb_read_strobe  = 1'b0;
        pb_write_strobe = 1'b0;
        pb_out_port     = 8'h00;
        step(3);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_event_any", 32'(event_any), 32'h0);
        pb_reset = 1'b0;

        // Reset values of every port
        read_chk("rst_level",  8'h06, 8'h00, 1'b1);
        read_chk("rst_event",  8'h07, 8'h00, 1'b1);
        read_chk("rst_mask",   8'h0C, 8'h1F, 1'b1);
        read_chk("rst_repeat", 8'h0D, 8'h00, 1'b1);
        read_chk("other_port", 8'h20, 8'h00, 1'b0);

        // 3-cycle glitch on btn 2 is rejected
        pb_port_id = 8'h06;
        btn_in = 5'b00100;
        step(3);
        btn_in = 5'b00000;
        step(8);
        chk("glitch_level", 32'(rd_data), 32'h00);
        read_chk("glitch_event", 8'h07, 8'h00, 1'b1);

        // Held btn 2: event set 7 edges after the pin edge, event_any one later
        btn_in = 5'b00100;
        pb_port_id = 8'h07;
        step(7);
        chk("press_early_ev", 32'(rd_data), 32'h00);
        chk("press_early_any", 32'(event_any), 32'h0);
        step(1);
        chk("press_ev", 32'(rd_data), 32'h04);
        chk("press_any", 32'(event_any), 32'h1);
        read_chk("press_level", 8'h06, 8'h04, 1'b1);

        // Read-clear races with btn 0 being accepted: cleared bit goes, new bit stays
        btn_in = 5'b00101;
        pb_port_id = 8'h07;
        step(6);
        pb_read_strobe = 1'b1;
        chk("clr_rd_data", 32'(rd_data), 32'h04);
        step(1);
        pb_read_strobe = 1'b0;
        step(1);
        chk("clr_after", 32'(rd_data), 32'h01);
        pb_read_strobe = 1'b1;
        step(1);
        pb_read_strobe = 1'b0;
        step(1);
        chk("clr_empty", 32'(rd_data), 32'h00);

        // Release both; falling edges never create events
        btn_in = 5'b00000;
        step(10);
        read_chk("rel_event", 8'h07, 8'h00, 1'b1);
        read_chk("rel_level", 8'h06, 8'h00, 1'b1);

        // Auto-repeat on btn 0 with continuous read-clear
        write_port(8'h0D, 8'h01);
        read_chk("repeat_en", 8'h0D, 8'h01, 1'b1);
        pb_port_id     = 8'h07;
        pb_read_strobe = 1'b1;
        btn_in         = 5'b00001;
        prev_any       = event_any;
        for (int k = 1; k <= 90; k++) begin
            step(1);
            if (event_any && !prev_any) rises.push_back(k);
            prev_any = event_any;
            if (k == 60) btn_in = 5'b00000;
        end
        pb_read_strobe = 1'b0;
        chk("rep_count", 32'(rises.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("rep_time%0d", i), (i < rises.size()) ? 32'(rises[i]) : 32'hFFFF_FFFF, 32'(exp_rise[i]));
        step(2);
        chk("rep_quiet", 32'(event_any), 32'h0);

        // Simultaneous press, then mask write drops disabled pending bit
        write_port(8'h0D, 8'h00);
        pb_port_id = 8'h07;
        btn_in = 5'b00011;
        step(8);
        chk("dual_event", 32'(rd_data), 32'h03);
        write_port(8'h0C, 8'hFE);
        read_chk("mask_val", 8'h0C, 8'h1E, 1'b1);
        read_chk("mask_ev",  8'h07, 8'h02, 1'b1);
        btn_in = 5'b00010;
        step(10);
        btn_in = 5'b00011;
        step(10);
        read_chk("masked_press", 8'h07, 8'h02, 1'b1);
        read_chk("masked_level", 8'h06, 8'h03, 1'b1);

        // Reset mid-repeat on btn 1 while held
        btn_in = 5'b00000;
        step(10);
        write_port(8'h0D, 8'h02);
        btn_in = 5'b00010;
        step(15);
        chk("pre_rst_any", 32'(event_any), 32'h1);
        pb_reset = 1'b1;
        #1;
        chk("mid_rst_rd", 32'(rd_data), 32'h00);
        chk("mid_rst_hit", 32'(rd_hit), 32'h0);
        chk("mid_rst_any", 32'(event_any), 32'h0);
        step(3);
        pb_reset   = 1'b0;
        pb_port_id = 8'h0C;
        step(1);
        chk("post_rst_mask", 32'(rd_data), 32'h1F);
        pb_port_id = 8'h07;
        step(5);
        chk("post_rst_ev0", 32'(rd_data), 32'h00);
        chk("post_rst_any0", 32'(event_any), 32'h0);
        step(1);
        chk("post_rst_any1", 32'(event_any), 32'h0);
        step(1);
        chk("post_rst_any2", 32'(event_any), 32'h1);
        chk("post_rst_ev", 32'(rd_data), 32'h02);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
